// File: rtl/frame_streamer_pkg.sv
// Shared types for the frame streamer: FSM state encoding and counter width helper.
package frame_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;

  // Counter width for a count range of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_streamer_skid_fifo.sv
// Two-entry skid FIFO holding {eof, eol, pixel}; the producer never pushes into a full FIFO.
module stream_skid_fifo #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset because its head drives a module output that must read 0 out of reset.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/frame_streamer.sv
// Reads a stored frame from a 1-cycle-latency RAM in raster order and streams it with eol/eof tags.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int BUFFER_LENGTH = 2000,
  parameter int MAX_ROWS      = 2000,
  parameter int ADDR_WIDTH    = 22
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [cnt_width(BUFFER_LENGTH)-1:0] frame_column_size,
  input  logic [cnt_width(MAX_ROWS)-1:0]      frame_row_size,
  output logic                              mem_en,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic [DATA_WIDTH-1:0]             out_point,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic                              eol,
  output logic                              eof,
  output logic                              busy,
  output logic                              done
);

  localparam int COL_W = cnt_width(BUFFER_LENGTH);
  localparam int ROW_W = cnt_width(MAX_ROWS);
  localparam int FW    = DATA_WIDTH + 2;

  state_t            r_state;
  logic [COL_W-1:0]  r_cols;
  logic [COL_W-1:0]  r_icol;
  logic [ROW_W-1:0]  r_rows;
  logic [ROW_W-1:0]  r_irow;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic              r_inflight;
  logic              r_inf_eol;
  logic              r_inf_eof;
  logic              r_busy;
  logic              r_done;

  logic [FW-1:0]     w_head;
  logic [1:0]        w_count;
  logic [2:0]        w_occ;
  logic              w_valid;
  logic              w_xfer;
  logic              w_issue;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_last_issue;

  // A slot freed by this cycle's transfer may be refilled at once, which keeps the stream gap-free.
  assign w_valid      = (w_count != 2'd0);
  assign w_xfer       = w_valid & ready_in;
  assign w_occ        = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_xfer};
  assign w_issue      = (r_state == ST_STREAM) && (w_occ < 3'd2);
  assign w_last_col   = (r_icol == r_cols - COL_W'(1));
  assign w_last_row   = (r_irow == r_rows - ROW_W'(1));
  assign w_last_issue = w_last_col & w_last_row;

  stream_skid_fifo #(
    .WIDTH(FW)
  ) u_skid_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  ({r_inf_eof, r_inf_eol, mem_rdata}),
    .i_pop   (w_xfer),
    .o_data  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cols     <= '0;
      r_rows     <= '0;
      r_icol     <= '0;
      r_irow     <= '0;
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_inf_eol  <= 1'b0;
      r_inf_eof  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values, independent of statement order.
      r_inflight <= w_issue;
      r_inf_eol  <= w_last_col;
      r_inf_eof  <= w_last_issue;

      if (w_issue) begin
        if (!w_last_issue) begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
        if (w_last_col) begin
          r_icol <= '0;
          r_irow <= r_irow + ROW_W'(1);
        end else begin
          r_icol <= r_icol + COL_W'(1);
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cols <= frame_column_size;
            r_rows <= frame_row_size;
            r_icol <= '0;
            r_irow <= '0;
            r_addr <= '0;
            r_busy <= 1'b1;
            if (frame_column_size == '0 || frame_row_size == '0) begin
              r_state <= ST_FINISH;
            end else begin
              r_state <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (w_issue && w_last_issue) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_xfer && w_head[DATA_WIDTH+1]) begin
            r_state <= ST_FINISH;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_FINISH: begin
          // An empty frame arrives here with busy still set and spends one extra cycle raising done.
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en    = w_issue;
  assign mem_addr  = r_addr;
  assign valid_out = w_valid;
  assign out_point = w_head[DATA_WIDTH-1:0];
  assign eol       = w_valid & w_head[DATA_WIDTH];
  assign eof       = w_valid & w_head[DATA_WIDTH+1];
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_frame_streamer.sv
// Self-checking bench for frame_streamer: RAM model, raster-order reference and backpressure patterns.
module tb_frame_streamer;

  localparam int DW = 8;
  localparam int AW = 22;
  localparam int CW = 11;
  localparam int RW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ready_in = 1'b0;
  logic [CW-1:0] fcs = '0;
  logic [RW-1:0] frs = '0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] out_point;
  logic          valid_out;
  logic          eol;
  logic          eof;
  logic          busy;
  logic          done;

  logic [DW-1:0] ram [0:4095];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  frame_streamer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .frame_column_size (fcs),
    .frame_row_size    (frs),
    .mem_en            (mem_en),
    .mem_addr          (mem_addr),
    .mem_rdata         (mem_rdata),
    .out_point         (out_point),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .eol               (eol),
    .eof               (eof),
    .busy              (busy),
    .done              (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // RAM with one cycle of read latency: address seen this cycle, data presented next cycle.
  initial begin : ram_model
    logic          pend_en;
    logic [AW-1:0] pend_addr;
    forever begin
      @(negedge clk);
      pend_en   = mem_en;
      pend_addr = mem_addr;
      @(posedge clk);
      #1;
      if (pend_en) mem_rdata = ram[pend_addr[11:0]];
    end
  end

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 4 == 0) || (c % 4 == 3);
      2:       return (c >= 10);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic fill_ram(input int n, input bit ramp);
    for (int i = 0; i < n; i++) ram[i] = ramp ? DW'(i) : DW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, 32'(mem_en), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_valid"}, 32'(valid_out), 0);
    check({tag, "_point"}, 32'(out_point), 0);
    check({tag, "_eol"}, 32'(eol), 0);
    check({tag, "_eof"}, 32'(eof), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // Streams one frame; reference: pixel k = ram[k], eol at k%cols==cols-1, eof at k==n-1.
  task automatic run_frame(input int cols, input int rows, input int mode,
                           input bit mid_start, input int abort_at);
    int            n;
    int            k;
    int            reads;
    int            first_x;
    int            last_x;
    int            budget;
    bit            seen_done;
    bit            prev_stall;
    bit            aborted;
    logic [DW+1:0] prev_word;
    n = cols * rows;
    k = 0; reads = 0; first_x = -1; last_x = -1;
    seen_done = 0; prev_stall = 0; aborted = 0; prev_word = '0;
    budget = 8 * n + 40;

    @(posedge clk); #1;
    start = 1'b1; fcs = CW'(cols); frs = RW'(rows);
    @(posedge clk); #1;
    start = 1'b0; ready_in = ready_for(mode, 0);
    fcs = CW'($urandom_range(1, 7)); frs = RW'($urandom_range(1, 7));
    @(negedge clk);
    check("busy_on_start", 32'(busy), 1);
    check("first_mem_en", 32'(mem_en), (n != 0) ? 1 : 0);

    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        ready_in = ready_for(mode, cyc);
        start = mid_start && (cyc == 4);
        if (start) begin fcs = CW'(2); frs = RW'(1); end
        @(negedge clk);
      end
      if (prev_stall) begin
        check("stall_valid", 32'(valid_out), 1);
        check("stall_hold", 32'({eof, eol, out_point}), 32'(prev_word));
      end
      prev_stall = valid_out & !ready_in;
      prev_word  = {eof, eol, out_point};
      if (mem_en) begin
        check("read_overrun", 32'(reads < n), 1);
        check("mem_addr", 32'(mem_addr), reads);
        reads++;
      end
      if (mode == 2 && cyc == 9) check("reads_while_stalled", reads, 2);
      if (done) begin
        seen_done = 1;
        check("done_cycle", cyc, (n == 0) ? 1 : last_x + 1);
        check("done_xfers", k, n);
        check("busy_with_done", 32'(busy), 0);
        break;
      end
      check("busy_mid", 32'(busy), 1);
      if (valid_out && ready_in) begin
        if (k >= n) begin
          check("extra_xfer", k, n - 1);
        end else begin
          if (first_x < 0) first_x = cyc;
          check("pixel", 32'(out_point), 32'(ram[k]));
          check("eol", 32'(eol), 32'((k % cols) == cols - 1));
          check("eof", 32'(eof), 32'(k == n - 1));
          if (k == n - 1) last_x = cyc;
        end
        k++;
        if (k == abort_at) begin
          aborted = 1;
          break;
        end
      end
    end

    if (aborted) begin
      rst_n = 1'b0;
      #1;
      check_all_zero("abort");
      repeat (3) begin @(negedge clk); check("done_in_reset", 32'(done), 0); end
      rst_n = 1'b1;
      ready_in = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("no_done_after_reset", 32'(done), 0);
        check("idle_after_reset", 32'(busy), 0);
      end
    end else begin
      check("done_seen", 32'(seen_done), 1);
      if (mode == 0 && n > 0) begin
        check("first_xfer_cycle", first_x, 2);
        check("last_xfer_cycle", last_x, n + 1);
      end
      if (mode == 2) check("release_gapfree", last_x, 10 + n - 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_pulse_width", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_valid", 32'(valid_out), 0);
    end
  endtask

  initial begin
    ready_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    fill_ram(12, 1'b1);
    run_frame(4, 3, 0, 1'b0, -1);
    run_frame(4, 3, 1, 1'b0, -1);
    run_frame(4, 3, 2, 1'b0, -1);
    run_frame(0, 5, 0, 1'b0, -1);
    run_frame(4, 3, 0, 1'b0, 5);
    run_frame(4, 3, 0, 1'b0, -1);
    run_frame(4, 3, 0, 1'b1, -1);
    fill_ram(1, 1'b0);
    run_frame(1, 1, 0, 1'b0, -1);

    for (int t = 0; t < 6; t++) begin
      int c;
      int r;
      c = int'($urandom_range(1, 7));
      r = int'($urandom_range(1, 5));
      fill_ram(c * r, 1'b0);
      run_frame(c, r, 3, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
